fixed_weight_loc_gen: RTL and testbench
=======================================

Name: fixed_weight_loc_gen

Overview:
- Upstream stage of loc_based_adder: fills the location memory with WEIGHT distinct bit positions in [0, N).
- Consumes 24-bit random words from the SHAKE/PRNG stage over a valid/ready handshake.
- Rejection-samples each word, reduces it mod N with a bit-serial reducer, and rejects duplicates by scanning the locations already stored.
- Pulses done when all WEIGHT locations are written; the adder can then start.

Parameters:
- parameter_set, "hqc128": selects N/M/WEIGHT ("hqc128", "hqc192", "hqc256").
- N, 17_669 / 35_851 / 57_637: vector length.
- M, 15 / 16 / 16: location width.
- WEIGHT, 66 / 100 / 131: locations to generate.
- RAND_W, 24: random word width.
- THRESHOLD, floor(2^RAND_W/N)*N (16_767_881 for hqc128): rejection bound.
- LOG_WEIGHT, CLOG2(WEIGHT): location memory address width.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; synchronous, active-high.
- start  in  1  begin generation; sampled only in IDLE.
- rand_in  in  RAND_W  random word.
- rand_valid  in  1  rand_in valid.
- rand_ready  out  1  block accepts rand_in this cycle.
- loc_wr_en  out  1  location memory write strobe.
- loc_wr_addr  out  LOG_WEIGHT  write address.
- loc_out  out  M  location written.
- loc_rd_en  out  1  location memory read strobe (duplicate scan).
- loc_rd_addr  out  LOG_WEIGHT  read address.
- loc_in  in  M  read data, valid 1 cycle after loc_rd_en.
- busy  out  1  high in every state except IDLE.
- done  out  1  1-cycle completion pulse.

Behaviour:
- Synchronous active-high reset, applied in any state including mid-run: state=IDLE, count=0; rand_ready, loc_wr_en, loc_rd_en, busy, done = 0; loc_wr_addr, loc_rd_addr, loc_out = 0.
- Memory contents are not cleared by reset.
- Transfer rule: a word transfers when rand_valid & rand_ready. rand_ready is high only in FETCH.
- IDLE: start=1 -> FETCH, count<=0. start is ignored in every other state.
- FETCH, on transfer with rand_in >= THRESHOLD: word consumed and discarded; stay in FETCH; rand_ready stays high.
- FETCH, on transfer with rand_in < THRESHOLD: capture the word -> REDUCE.
- REDUCE: exactly RAND_W cycles, MSB first. Per cycle: r = 2r + bit; if r >= N then r = r - N. r is M+1 bits, cleared on entry. Result cand = r, always < N.
  - count==0 -> WRITE.
  - otherwise -> SCAN with idx=0.
- SCAN: loc_rd_en=1, loc_rd_addr=idx, idx++ each cycle while idx<count.
  - Compare loc_in==cand on the cycle after each read.
  - Any match: abort immediately, discard cand -> FETCH. Reads in flight are ignored.
  - Last compare (addr count-1) with no match -> WRITE.
  - No-match scan of k entries takes k+1 cycles.
- WRITE: 1 cycle. loc_wr_en=1, loc_wr_addr=count, loc_out=cand[M-1:0]; count++.
  - New count==WEIGHT -> DONE; otherwise -> FETCH.
- DONE: done=1 for exactly one cycle -> IDLE. busy drops in IDLE.
- Memory exclusivity: loc_wr_en and loc_rd_en are never high in the same cycle. The block never drives the location memory outside busy; the adder shares the port after done.
- Word starvation: rand_valid low in FETCH stalls indefinitely with no side effects.
- Stored locations are pairwise distinct, in acceptance order at addresses 0..WEIGHT-1.

Test Plan:
- hqc128, WEIGHT overridden to 4; feed 5, 17_676, 100, 16_767_880 -> writes loc 5@0, 7@1, 100@2, 17_668@3; done pulses once; busy falls the following cycle.
- Rejection: feed 16_767_881, then 16_777_215, then 3 -> both large words consumed with no write; loc 3 written at addr 0.
- Duplicate: feed 5, 17_674 (≡5), 9 -> only 5@0 and 9@1 written. The scan for 17_674 aborts after its match compare; 9's scan takes 2 cycles.
- Stall: hold rand_valid=0 for 50 cycles inside FETCH -> no writes or reads; rand_ready held high; resumes correctly on valid.
- Reset mid-run: assert rst during REDUCE of the 2nd word -> next cycle all outputs 0, IDLE; a fresh start rewrites from addr 0.
- Full hqc128 run (WEIGHT=66) with random words -> 66 distinct values <17_669 written; done exactly once; never loc_wr_en & loc_rd_en together.

Source files
------------

// File: rtl/fixed_weight_loc_gen.sv
// Generates WEIGHT distinct locations in [0, N) from a stream of random words:
// rejection sampling, bit-serial mod-N reduction, duplicate scan, then write.
module fixed_weight_loc_gen #(
    parameter string parameter_set = "hqc128",
    parameter int N          = (parameter_set == "hqc256") ? 57637 :
                               (parameter_set == "hqc192") ? 35851 : 17669,
    parameter int M          = (parameter_set == "hqc128") ? 15 : 16,
    parameter int WEIGHT     = (parameter_set == "hqc256") ? 131 :
                               (parameter_set == "hqc192") ? 100 : 66,
    parameter int RAND_W     = 24,
    parameter int THRESHOLD  = ((2 ** RAND_W) / N) * N,
    parameter int LOG_WEIGHT = $clog2(WEIGHT)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [RAND_W-1:0]     rand_in,
    input  logic                  rand_valid,
    output logic                  rand_ready,
    output logic                  loc_wr_en,
    output logic [LOG_WEIGHT-1:0] loc_wr_addr,
    output logic [M-1:0]          loc_out,
    output logic                  loc_rd_en,
    output logic [LOG_WEIGHT-1:0] loc_rd_addr,
    input  logic [M-1:0]          loc_in,
    output logic                  busy,
    output logic                  done
);

    // count must be able to hold WEIGHT itself
    localparam int CW = LOG_WEIGHT + 1;
    localparam int BW = $clog2(RAND_W);
    localparam logic [CW-1:0]     WEIGHT_C = CW'(WEIGHT);
    localparam logic [RAND_W-1:0] THRESH_C = RAND_W'(THRESHOLD);
    localparam logic [M:0]        N_C      = (M + 1)'(N);
    localparam logic [BW-1:0]     LAST_BIT = BW'(RAND_W - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_REDUCE, S_SCAN, S_WRITE, S_DONE
    } state_t;

    state_t            state, state_next;
    logic [CW-1:0]     count;
    logic [CW-1:0]     idx;
    logic [RAND_W-1:0] word;
    logic [M-1:0]      r;
    logic [BW-1:0]     bit_cnt;
    logic              pend;
    logic              pend_last;

    logic [M:0]   r_shift;
    logic [M-1:0] r_next;
    logic         accept;
    logic         scan_rd;
    logic         match;

    // r stays below N < 2^M, so only the doubled intermediate needs M+1 bits
    assign r_shift = {r, word[RAND_W-1]};
    assign r_next  = (r_shift >= N_C) ? M'(r_shift - N_C) : r_shift[M-1:0];
    assign accept  = rand_in < THRESH_C;
    assign scan_rd = (state == S_SCAN) && (idx < count);
    assign match   = pend && (loc_in == r);

    always_comb begin
        state_next  = state;
        rand_ready  = 1'b0;
        loc_wr_en   = 1'b0;
        loc_wr_addr = '0;
        loc_out     = '0;
        loc_rd_en   = 1'b0;
        loc_rd_addr = '0;
        busy        = (state != S_IDLE);
        done        = 1'b0;
        case (state)
            S_IDLE: if (start) state_next = S_FETCH;
            S_FETCH: begin
                rand_ready = 1'b1;
                if (rand_valid && accept) state_next = S_REDUCE;
            end
            S_REDUCE: begin
                if (bit_cnt == LAST_BIT)
                    state_next = (count == '0) ? S_WRITE : S_SCAN;
            end
            S_SCAN: begin
                loc_rd_en   = scan_rd;
                loc_rd_addr = scan_rd ? idx[LOG_WEIGHT-1:0] : '0;
                // a hit wins over end-of-scan; reads still in flight are dropped
                if (match)                  state_next = S_FETCH;
                else if (pend && pend_last) state_next = S_WRITE;
            end
            S_WRITE: begin
                loc_wr_en   = 1'b1;
                loc_wr_addr = count[LOG_WEIGHT-1:0];
                loc_out     = r;
                state_next  = (count + CW'(1) == WEIGHT_C) ? S_DONE : S_FETCH;
            end
            S_DONE: begin
                done       = 1'b1;
                state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            count     <= '0;
            idx       <= '0;
            word      <= '0;
            r         <= '0;
            bit_cnt   <= '0;
            pend      <= 1'b0;
            pend_last <= 1'b0;
        end else begin
            state     <= state_next;
            pend      <= scan_rd;
            pend_last <= scan_rd && (idx == count - CW'(1));
            case (state)
                S_IDLE: if (start) count <= '0;
                S_FETCH: begin
                    if (rand_valid && accept) begin
                        word    <= rand_in;
                        r       <= '0;
                        bit_cnt <= '0;
                    end
                end
                S_REDUCE: begin
                    r       <= r_next;
                    word    <= {word[RAND_W-2:0], 1'b0};
                    bit_cnt <= bit_cnt + BW'(1);
                    idx     <= '0;
                end
                S_SCAN:  if (scan_rd) idx <= idx + CW'(1);
                S_WRITE: count <= count + CW'(1);
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fixed_weight_loc_gen.sv
// Bench for fixed_weight_loc_gen: directed table on a WEIGHT=4 instance and a
// randomized full hqc128 run checked against a set-based reference model.
module tb_fixed_weight_loc_gen;

    localparam int NQ   = 17669;
    localparam int THR  = 16767881;
    localparam int WFUL = 66;

    logic clk, rst;

    logic        start_a, rand_valid_a, rand_ready_a;
    logic [23:0] rand_in_a;
    logic        wr_en_a, rd_en_a, busy_a, done_a;
    logic [1:0]  wr_addr_a, rd_addr_a;
    logic [14:0] loc_out_a, loc_in_a;

    logic        start_b, rand_valid_b, rand_ready_b;
    logic [23:0] rand_in_b;
    logic        wr_en_b, rd_en_b, busy_b, done_b;
    logic [6:0]  wr_addr_b, rd_addr_b;
    logic [14:0] loc_out_b, loc_in_b;

    fixed_weight_loc_gen #(.parameter_set("hqc128"), .WEIGHT(4)) dut_a (
        .clk(clk), .rst(rst), .start(start_a), .rand_in(rand_in_a),
        .rand_valid(rand_valid_a), .rand_ready(rand_ready_a),
        .loc_wr_en(wr_en_a), .loc_wr_addr(wr_addr_a), .loc_out(loc_out_a),
        .loc_rd_en(rd_en_a), .loc_rd_addr(rd_addr_a), .loc_in(loc_in_a),
        .busy(busy_a), .done(done_a));

    fixed_weight_loc_gen #(.parameter_set("hqc128")) dut_b (
        .clk(clk), .rst(rst), .start(start_b), .rand_in(rand_in_b),
        .rand_valid(rand_valid_b), .rand_ready(rand_ready_b),
        .loc_wr_en(wr_en_b), .loc_wr_addr(wr_addr_b), .loc_out(loc_out_b),
        .loc_rd_en(rd_en_b), .loc_rd_addr(rd_addr_b), .loc_in(loc_in_b),
        .busy(busy_b), .done(done_b));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // location memories, 1-cycle read latency
    logic [14:0] mem_a [4];
    logic [14:0] mem_b [128];
    always @(posedge clk) begin
        if (wr_en_a) mem_a[wr_addr_a] <= loc_out_a;
        if (rd_en_a) loc_in_a <= mem_a[rd_addr_a];
        if (wr_en_b) mem_b[wr_addr_b] <= loc_out_b;
        if (rd_en_b) loc_in_b <= mem_b[rd_addr_b];
    end

    int total = 0, bad = 0;
    int done_cnt_a = 0, done_cnt_b = 0, excl_bad = 0, busy_bad = 0;
    logic prev_done_a = 1'b0;

    always @(negedge clk) begin
        if (done_a) done_cnt_a <= done_cnt_a + 1;
        if (done_b) done_cnt_b <= done_cnt_b + 1;
        if ((wr_en_a && rd_en_a) || (wr_en_b && rd_en_b) ||
            (!busy_a && (wr_en_a || rd_en_a)) || (!busy_b && (wr_en_b || rd_en_b)))
            excl_bad <= excl_bad + 1;
        if (prev_done_a && busy_a) busy_bad <= busy_bad + 1;
        prev_done_a <= done_a;
    end

    task automatic chk(input string nm, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", nm, act, exp);
        end
    endtask

    task automatic fresh_a();
        rst = 1'b1; start_a = 1'b0; rand_valid_a = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0; start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
    endtask

    // Offers one word; reports latency (in cycles after the transfer) of the
    // write and of the return to FETCH/IDLE.
    task automatic feed_a(input logic [23:0] w, output int wr_lat, output int rdy_lat,
                          output int nwr, output int waddr, output int wval);
        int n;
        wr_lat = -1; rdy_lat = -1; nwr = 0; waddr = -1; wval = -1;
        rand_in_a = w; rand_valid_a = 1'b1;
        n = 0;
        while (!rand_ready_a && n < 500) begin @(negedge clk); n++; end
        if (!rand_ready_a) begin
            total++; bad++; rand_valid_a = 1'b0;
            $display("FAIL feed_timeout: word %0d never accepted", w);
            return;
        end
        @(negedge clk);
        rand_valid_a = 1'b0;
        for (int k = 1; k < 500; k++) begin
            if (wr_en_a) begin nwr++; wr_lat = k; waddr = wr_addr_a; wval = loc_out_a; end
            if (rand_ready_a || !busy_a) begin rdy_lat = k; break; end
            @(negedge clk);
        end
        if (rdy_lat < 0) begin
            total++; bad++;
            $display("FAIL settle_timeout: word %0d", w);
        end
    endtask

    typedef struct {
        bit          fresh;
        logic [23:0] word;
        int          nwr;
        int          addr;
        int          loc;
        int          lat;
    } vec_t;

    vec_t vt[10];
    int wl, rl, nw, wa, wv;
    int stall_bad, seq_bad, dist_bad, r, c, w;
    bit dup;
    int exp_q[$];
    int wa_q[$], wv_q[$];

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vt[0] = '{1'b1, 24'd5,        1, 0, 5,     25};
        vt[1] = '{1'b0, 24'd17676,    1, 1, 7,     27};
        vt[2] = '{1'b0, 24'd100,      1, 2, 100,   28};
        vt[3] = '{1'b0, 24'd16767880, 1, 3, 17668, 29};
        vt[4] = '{1'b1, 24'd16767881, 0, 0, 0,     1};
        vt[5] = '{1'b0, 24'd16777215, 0, 0, 0,     1};
        vt[6] = '{1'b0, 24'd3,        1, 0, 3,     25};
        vt[7] = '{1'b1, 24'd5,        1, 0, 5,     25};
        vt[8] = '{1'b0, 24'd17674,    0, 0, 0,     27};
        vt[9] = '{1'b0, 24'd9,        1, 1, 9,     27};

        rst = 1'b1; start_a = 0; start_b = 0; rand_valid_a = 0; rand_valid_b = 0;
        rand_in_a = '0; rand_in_b = '0;
        repeat (3) @(negedge clk);
        chk("reset_outs_a", {rand_ready_a, wr_en_a, rd_en_a, busy_a, done_a,
                             wr_addr_a, rd_addr_a, loc_out_a}, 0);
        chk("reset_outs_b", {rand_ready_b, wr_en_b, rd_en_b, busy_b, done_b,
                             wr_addr_b, rd_addr_b, loc_out_b}, 0);

        for (int i = 0; i < 10; i++) begin
            if (vt[i].fresh) fresh_a();
            feed_a(vt[i].word, wl, rl, nw, wa, wv);
            chk($sformatf("v%0d_nwr", i), nw, vt[i].nwr);
            if (vt[i].nwr == 1) begin
                chk($sformatf("v%0d_addr", i), wa, vt[i].addr);
                chk($sformatf("v%0d_loc", i), wv, vt[i].loc);
                chk($sformatf("v%0d_wr_lat", i), wl, vt[i].lat);
            end else begin
                chk($sformatf("v%0d_rdy_lat", i), rl, vt[i].lat);
            end
            if (i == 3) begin
                @(negedge clk);
                chk("done_once", done_cnt_a, 1);
                chk("busy_after_done", busy_bad, 0);
                chk("idle_busy", busy_a, 0);
            end
        end

        // stall in FETCH
        fresh_a();
        stall_bad = 0;
        repeat (50) begin
            @(negedge clk);
            if (!rand_ready_a || wr_en_a || rd_en_a) stall_bad++;
        end
        chk("stall_side_effects", stall_bad, 0);
        feed_a(24'd42, wl, rl, nw, wa, wv);
        chk("stall_resume_addr", wa, 0);
        chk("stall_resume_loc", wv, 42);
        chk("stall_resume_lat", wl, 25);

        // reset during REDUCE of the second word
        fresh_a();
        feed_a(24'd11, wl, rl, nw, wa, wv);
        chk("pre_rst_loc", wv, 11);
        rand_in_a = 24'd22; rand_valid_a = 1'b1;
        @(negedge clk);
        rand_valid_a = 1'b0;
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("midrun_rst_outs", {rand_ready_a, wr_en_a, rd_en_a, busy_a, done_a,
                                wr_addr_a, rd_addr_a, loc_out_a}, 0);
        rst = 1'b0; start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        feed_a(24'd33, wl, rl, nw, wa, wv);
        chk("post_rst_addr", wa, 0);
        chk("post_rst_loc", wv, 33);
        chk("post_rst_lat", wl, 25);

        // randomized full hqc128 run
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0; start_b = 1'b1;
        @(negedge clk);
        start_b = 1'b0;
        for (int cyc = 0; cyc < 30000 && done_cnt_b == 0; cyc++) begin
            if (wr_en_b) begin wa_q.push_back(int'(wr_addr_b)); wv_q.push_back(int'(loc_out_b)); end
            r = $urandom_range(0, 7);
            if (r == 0) w = $urandom_range(THR, 24'hFFFFFF);
            else if (r == 1 && exp_q.size() > 0)
                w = exp_q[$urandom_range(0, exp_q.size() - 1)] + NQ * $urandom_range(0, 948);
            else w = $urandom_range(0, 24'hFFFFFF);
            rand_in_b = w[23:0];
            rand_valid_b = ($urandom_range(0, 3) != 0);
            if (rand_valid_b && rand_ready_b && w < THR) begin
                c = w % NQ;
                dup = 1'b0;
                foreach (exp_q[j]) if (exp_q[j] == c) dup = 1'b1;
                if (!dup) exp_q.push_back(c);
            end
            @(negedge clk);
        end
        rand_valid_b = 1'b0;
        repeat (3) @(negedge clk);
        chk("full_done_cnt", done_cnt_b, 1);
        chk("full_nwr", wv_q.size(), WFUL);
        chk("full_model_n", exp_q.size(), WFUL);
        seq_bad = 0; dist_bad = 0;
        for (int i = 0; i < wv_q.size() && i < exp_q.size(); i++) begin
            if (wv_q[i] != exp_q[i] || wa_q[i] != i) seq_bad++;
            if (wv_q[i] >= NQ) dist_bad++;
            for (int j = 0; j < i; j++) if (wv_q[j] == wv_q[i]) dist_bad++;
        end
        chk("full_seq_vs_model", seq_bad, 0);
        chk("full_distinct_range", dist_bad, 0);
        chk("mem_exclusive", excl_bad, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
